// File: rtl/block_enable_decoder_if.sv
// Request/enable bundle between the cache FSM (master) and the block-enable decoder (slave).
`timescale 1ns/1ps
interface block_enable_decoder_if #(
   parameter int ADDR_W   = 16,
   parameter int SET_BITS = 6,
   parameter int WAYS     = 2
);
   localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int NUM_BLOCKS = (1 << SET_BITS) * WAYS;

   logic [ADDR_W-1:0]     addr_in;
   logic [WAY_BITS-1:0]   way_in;
   logic                  req_valid;
   logic                  req_ready;
   logic                  flush_req;
   logic [NUM_BLOCKS-1:0] blk_en;
   logic                  busy;
   logic                  flush_done;

   modport master (
      output addr_in, way_in, req_valid, flush_req,
      input  req_ready, blk_en, busy, flush_done
   );

   modport slave (
      input  addr_in, way_in, req_valid, flush_req,
      output req_ready, blk_en, busy, flush_done
   );
endinterface

// File: rtl/block_enable_decoder.sv
// Registered one-hot block-enable decoder for cache data/meta arrays, with an optional
// flush sweep across all blocks compiled in when BLKDEC_FLUSH_EN is defined.
`timescale 1ns/1ps
module block_enable_decoder #(
   parameter int ADDR_W      = 16,
   parameter int OFFSET_BITS = 5,
   parameter int SET_BITS    = 6,
   parameter int WAYS        = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   block_enable_decoder_if.slave bus
);
   localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int NUM_BLOCKS = (1 << SET_BITS) * WAYS;
   localparam int IDX_BITS   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   logic [SET_BITS-1:0]   w_set;
   logic [IDX_BITS-1:0]   w_idx;
   logic [NUM_BLOCKS-1:0] w_onehot;
   logic                  w_unused;

   assign w_set    = bus.addr_in[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
   assign w_unused = &{1'b0, bus.addr_in, bus.way_in, bus.flush_req};

   // WAYS is a power of two, so set*WAYS + way is a plain concatenation.
   generate
      if (WAYS > 1) begin : g_multi_way
         assign w_idx = {w_set, bus.way_in};
      end else begin : g_single_way
         assign w_idx = w_set;
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_dec
         assign w_onehot[gi] = (w_idx == IDX_BITS'(gi));
      end
   endgenerate

   logic [NUM_BLOCKS-1:0] r_blk_en;

`ifdef BLKDEC_FLUSH_EN
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SWEEP = 1'b1;

   logic [0:0]          r_state;
   logic [IDX_BITS-1:0] r_cnt;
   logic                r_busy;
   logic                r_flush_done;
   logic                w_last;

   assign w_last        = (r_cnt == IDX_BITS'(NUM_BLOCKS - 1));
   assign bus.req_ready = (r_state == S_IDLE) && !bus.flush_req;

   // r_cnt is the index of the block currently enabled; the enable itself shifts along with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_blk_en     <= '0;
         r_busy       <= 1'b0;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            S_SWEEP: begin
               if (w_last) begin
                  r_state      <= S_IDLE;
                  r_cnt        <= '0;
                  r_blk_en     <= '0;
                  r_busy       <= 1'b0;
                  r_flush_done <= 1'b1;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
                  r_blk_en <= r_blk_en << 1;
               end
            end
            default: begin
               if (bus.flush_req) begin
                  r_state  <= S_SWEEP;
                  r_cnt    <= '0;
                  r_blk_en <= NUM_BLOCKS'(1);
                  r_busy   <= 1'b1;
               end else begin
                  r_state  <= S_IDLE;
                  r_blk_en <= bus.req_valid ? w_onehot : '0;
                  r_busy   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.flush_done = r_flush_done;
`else
   assign bus.req_ready  = 1'b1;
   assign bus.busy       = 1'b0;
   assign bus.flush_done = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_en <= '0;
      end else begin
         r_blk_en <= bus.req_valid ? w_onehot : '0;
      end
   end
`endif

   assign bus.blk_en = r_blk_en;

endmodule

// File: tb/tb_block_enable_decoder.sv
// Bench for block_enable_decoder: default build (2 ways, 6 set bits) and a 1-way/7-set-bit build.
`timescale 1ns/1ps
module tb_block_enable_decoder;
   localparam int NB = 128;
   localparam logic [NB-1:0] ONE = 1;
`ifdef BLKDEC_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] stim_addr = '0;
   logic        stim_way  = 1'b0;
   logic        stim_rv   = 1'b0;
   logic        stim_fr   = 1'b0;

   block_enable_decoder_if #(.ADDR_W(16), .SET_BITS(6), .WAYS(2)) bus_a ();
   block_enable_decoder_if #(.ADDR_W(16), .SET_BITS(7), .WAYS(1)) bus_b ();

   assign bus_a.addr_in   = stim_addr;
   assign bus_a.way_in    = stim_way;
   assign bus_a.req_valid = stim_rv;
   assign bus_a.flush_req = stim_fr;
   assign bus_b.addr_in   = stim_addr;
   assign bus_b.way_in    = stim_way;
   assign bus_b.req_valid = stim_rv;
   assign bus_b.flush_req = stim_fr;

   block_enable_decoder #(.ADDR_W(16), .OFFSET_BITS(5), .SET_BITS(6), .WAYS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a)
   );
   block_enable_decoder #(.ADDR_W(16), .OFFSET_BITS(5), .SET_BITS(7), .WAYS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Block index from the address arithmetic: set field value times ways plus way.
   function automatic int exp_index(input int inst, input logic [15:0] a, input logic w);
      int setb;
      int ways;
      int set_field;
      setb      = (inst == 0) ? 6 : 7;
      ways      = (inst == 0) ? 2 : 1;
      set_field = (int'(a) >> 5) % (1 << setb);
      return (ways > 1) ? set_field * ways + int'(w) : set_field;
   endfunction

   // Model: a sweep is "the flush edge number", and each output is a function of elapsed edges.
   logic [NB-1:0] m_blk    [2];
   logic          m_busy   [2];
   logic          m_done   [2];
   logic          m_active [2];
   longint        m_start  [2];
   longint        edge_no;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_no <= 0;
         for (int i = 0; i < 2; i++) begin
            m_blk[i] <= '0; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
            m_active[i] <= 1'b0; m_start[i] <= 0;
         end
      end else begin
         edge_no <= edge_no + 1;
         for (int i = 0; i < 2; i++) begin
            m_done[i] <= 1'b0;
            if (FLUSH && m_active[i]) begin
               if (edge_no - m_start[i] < NB) begin
                  m_blk[i]  <= ONE << (edge_no - m_start[i]);
                  m_busy[i] <= 1'b1;
               end else begin
                  m_blk[i] <= '0; m_busy[i] <= 1'b0; m_done[i] <= 1'b1; m_active[i] <= 1'b0;
               end
            end else if (FLUSH && stim_fr) begin
               m_active[i] <= 1'b1; m_start[i] <= edge_no; m_blk[i] <= ONE; m_busy[i] <= 1'b1;
            end else begin
               m_busy[i] <= 1'b0;
               m_blk[i]  <= stim_rv ? (ONE << exp_index(i, stim_addr, stim_way)) : '0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("a_blk_en", bus_a.blk_en, m_blk[0]);
      check("a_busy", NB'(bus_a.busy), NB'(m_busy[0]));
      check("a_flush_done", NB'(bus_a.flush_done), NB'(m_done[0]));
      check("a_req_ready", NB'(bus_a.req_ready), NB'(!m_active[0] && !(FLUSH && stim_fr)));
      check("b_blk_en", bus_b.blk_en, m_blk[1]);
      check("b_busy", NB'(bus_b.busy), NB'(m_busy[1]));
      check("b_flush_done", NB'(bus_b.flush_done), NB'(m_done[1]));
      check("b_req_ready", NB'(bus_b.req_ready), NB'(!m_active[1] && !(FLUSH && stim_fr)));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NB-1:0] bit_at(input int k);
      logic [NB-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   logic [15:0] vec_addr [6] = '{16'h0000, 16'h0123, 16'hF3A0, 16'h0560, 16'h7FFF, 16'h8020};
   logic        vec_way  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_blk_en", bus_a.blk_en, '0);
      check("reset_busy", NB'(bus_a.busy), '0);

      // Plain decodes, including address bits outside the set field.
      stim_addr = 16'h0020; stim_way = 1'b0; stim_rv = 1'b1; step();
      check("dec_0020_a", bus_a.blk_en, bit_at(2));
      check("dec_0020_b", bus_b.blk_en, bit_at(1));
      stim_addr = 16'h07E0; stim_way = 1'b1; step();
      check("dec_07e0_a", bus_a.blk_en, bit_at(127));
      check("dec_07e0_b", bus_b.blk_en, bit_at(63));
      stim_rv = 1'b0; step();
      check("idle_zero_a", bus_a.blk_en, '0);
      stim_addr = 16'h0FE0; stim_way = 1'b0; stim_rv = 1'b1; step();
      check("dec_0fe0_b", bus_b.blk_en, bit_at(127));
      check("dec_0fe0_a", bus_a.blk_en, bit_at(126));
      for (int i = 0; i < 6; i++) begin
         stim_addr = vec_addr[i]; stim_way = vec_way[i]; step();
      end
      stim_rv = 1'b0; step();

      // Flush and request together: flush wins.
      stim_addr = 16'h0040; stim_way = 1'b0; stim_rv = 1'b1; stim_fr = 1'b1;
      #1 check("simul_ready", NB'(bus_a.req_ready), NB'(!FLUSH));
      step();
      stim_fr = 1'b0;
      check("simul_blk", bus_a.blk_en, FLUSH ? bit_at(0) : bit_at(4));
      for (int k = 1; k < NB; k++) begin
         stim_addr = 16'(k * 97); stim_rv = (k < 100); step();
      end
      check("sweep_last_a", bus_a.blk_en, FLUSH ? bit_at(127) : '0);
      check("sweep_busy_a", NB'(bus_a.busy), NB'(FLUSH));
      step();
      check("done_pulse_a", NB'(bus_a.flush_done), NB'(FLUSH));
      check("done_blk_a", bus_a.blk_en, '0);
      check("done_busy_a", NB'(bus_a.busy), '0);
      stim_addr = 16'h0020; stim_rv = 1'b1; step();
      check("b2b_dec_a", bus_a.blk_en, bit_at(2));
      stim_rv = 1'b0; step();
      check("after_done_a", NB'(bus_a.flush_done), '0);

      // Reset in the middle of a sweep.
      stim_fr = 1'b1; step();
      stim_fr = 1'b0;
      repeat (50) step();
      check("step50_a", bus_a.blk_en, FLUSH ? bit_at(50) : '0);
      rst_n = 1'b0;
      #1;
      check("async_rst_blk", bus_a.blk_en, '0);
      check("async_rst_busy", NB'(bus_a.busy), '0);
      check("async_rst_done", NB'(bus_a.flush_done), '0);
      step(); step();
      rst_n = 1'b1;
      repeat (3) step();
      check("no_done_after_rst", NB'(bus_a.flush_done), '0);
      stim_fr = 1'b1; step();
      stim_fr = 1'b0;
      check("restart_bit0_a", bus_a.blk_en, FLUSH ? bit_at(0) : '0);
      check("restart_bit0_b", bus_b.blk_en, FLUSH ? bit_at(0) : '0);
      repeat (NB + 2) step();
      check("final_idle_busy", NB'(bus_a.busy), '0);
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
